// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN accelerator layer scheduler.
package cnn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ADVANCE,
        FINISH
    } sched_state_t;

    // A single-layer build still needs a 1-bit index port.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_layer_scheduler_if.sv
// Host start/done pair plus engine launch/completion handshake for the layer scheduler.
interface cnn_layer_scheduler_if #(
    parameter int unsigned NUM_LAYERS = 4
);
    localparam int unsigned IDX_W = cnn_pkg::idx_width(NUM_LAYERS);

    logic             start;
    logic             layer_done;
    logic             layer_start;
    logic [IDX_W-1:0] layer_idx;
    logic             buf_sel;
    logic             busy;
    logic             done;
    logic             error;

    modport master (
        input  start,
        input  layer_done,
        output layer_start,
        output layer_idx,
        output buf_sel,
        output busy,
        output done,
        output error
    );

    modport slave (
        output start,
        output layer_done,
        input  layer_start,
        input  layer_idx,
        input  buf_sel,
        input  busy,
        input  done,
        input  error
    );

endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter watchdog: clear reloads LOAD_VALUE, expired flags the last enabled cycle.
module cycle_timer #(
    parameter int unsigned LOAD_VALUE = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic expired
);
    localparam int unsigned CNT_W = $clog2(LOAD_VALUE + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= CNT_W'(LOAD_VALUE);
        end else if (en && count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
        end
    end

    // Fires on the LOAD_VALUE-th enabled cycle after a clear.
    assign expired = en && (count_q == CNT_W'(1));

endmodule

// File: rtl/cnn_layer_scheduler.sv
// Sequences NUM_LAYERS engine passes with ping-pong bank select.
// Optional per-layer watchdog enabled by defining CNN_SCHED_TIMEOUT_EN.
module cnn_layer_scheduler
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_LAYERS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    cnn_layer_scheduler_if.master bus
);
    localparam int unsigned      IDX_W    = idx_width(NUM_LAYERS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LAYERS - 1);

    if (NUM_LAYERS < 1 || TIMEOUT_CYCLES < 1) begin : gen_param_check
        $error("cnn_layer_scheduler: NUM_LAYERS and TIMEOUT_CYCLES must be >= 1");
    end

    sched_state_t     state_q;
    logic [IDX_W-1:0] layer_idx_q;
    logic             buf_sel_q;
    logic             layer_start_q;
    logic             busy_q;
    logic             done_q;

`ifdef CNN_SCHED_TIMEOUT_EN
    logic timer_expired;
    logic error_q;

    cycle_timer #(
        .LOAD_VALUE(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_q == LAUNCH),
        .en     (state_q == WAIT),
        .expired(timer_expired)
    );

    assign bus.error = error_q;
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            layer_idx_q   <= '0;
            buf_sel_q     <= 1'b0;
            layer_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
`ifdef CNN_SCHED_TIMEOUT_EN
            error_q       <= 1'b0;
`endif
        end else begin
            layer_start_q <= 1'b0;
            done_q        <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q       <= LAUNCH;
                        layer_start_q <= 1'b1;
                        busy_q        <= 1'b1;
`ifdef CNN_SCHED_TIMEOUT_EN
                        error_q       <= 1'b0;
`endif
                    end
                end
                LAUNCH: state_q <= WAIT;
                WAIT: begin
                    // Completion takes priority over a coincident watchdog expiry.
                    if (bus.layer_done) begin
                        state_q <= ADVANCE;
                    end
`ifdef CNN_SCHED_TIMEOUT_EN
                    else if (timer_expired) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                    end
`endif
                end
                ADVANCE: begin
                    if (layer_idx_q == LAST_IDX) begin
                        state_q <= FINISH;
                        done_q  <= 1'b1;
                    end else begin
                        state_q       <= LAUNCH;
                        layer_start_q <= 1'b1;
                        layer_idx_q   <= layer_idx_q + IDX_W'(1);
                        buf_sel_q     <= ~buf_sel_q;
                    end
                end
                FINISH: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    layer_idx_q <= '0;
                    buf_sel_q   <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.layer_start = layer_start_q;
    assign bus.layer_idx   = layer_idx_q;
    assign bus.buf_sel     = buf_sel_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_cnn_layer_scheduler.sv
// Directed self-checking bench for cnn_layer_scheduler (4-layer and 1-layer instances).
module tb_cnn_layer_scheduler;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus controls
    logic start4 = 1'b0, hold4 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
    logic resp_en = 1'b0, spur_en = 1'b0;
    logic resp_done = 1'b0, spur_done = 1'b0, spur_start = 1'b0;
    int   resp_cnt = 0;
    int   since = 100;

    cnn_layer_scheduler_if #(.NUM_LAYERS(4)) bus4 ();
    cnn_layer_scheduler_if #(.NUM_LAYERS(1)) bus1 ();

    assign bus4.start      = start4 | spur_start;
    assign bus4.layer_done = resp_done | spur_done | hold4;
    assign bus1.start      = start1;
    assign bus1.layer_done = hold1;

    cnn_layer_scheduler #(
        .NUM_LAYERS    (4),
        .TIMEOUT_CYCLES(16)
    ) u_dut4 (
        .clk(clk),
        .rst(rst),
        .bus(bus4.master)
    );

    cnn_layer_scheduler #(
        .NUM_LAYERS    (1),
        .TIMEOUT_CYCLES(16)
    ) u_dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1.master)
    );

    // Engine model: layer_done 5 cycles after each layer_start, plus optional spurious pulses
    // in LAUNCH (launch+0), WAIT (start at launch+2) and ADVANCE (launch+6).
    always @(negedge clk) begin
        if (bus4.layer_start) begin
            resp_cnt <= 5;
            since    <= 0;
        end else begin
            if (resp_cnt != 0) resp_cnt <= resp_cnt - 1;
            if (since < 100) since <= since + 1;
        end
        resp_done  <= resp_en && !bus4.layer_start && resp_cnt == 1;
        spur_done  <= spur_en && (bus4.layer_start || since == 5);
        spur_start <= spur_en && !bus4.layer_start && since == 1;
    end

    // Monitors
    int q_idx[$], q_buf[$], q_cyc[$];
    int done_cnt = 0, done_cyc = 0, done_err = 0;
    int l1_cnt = 0, l1_idx = 0, done1_cnt = 0, done1_cyc = 0, done1_err = 0, buf1_seen = 0;

    always @(negedge clk) begin
        if (bus4.layer_start) begin
            q_idx.push_back(int'(bus4.layer_idx));
            q_buf.push_back(int'(bus4.buf_sel));
            q_cyc.push_back(cyc);
        end
        if (bus4.done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            done_err <= int'(bus4.error);
        end
        if (bus1.layer_start) begin
            l1_cnt <= l1_cnt + 1;
            l1_idx <= int'(bus1.layer_idx);
        end
        if (bus1.done) begin
            done1_cnt <= done1_cnt + 1;
            done1_cyc <= cyc;
            done1_err <= int'(bus1.error);
        end
        if (bus1.buf_sel) buf1_seen <= 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc_wait();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int base);
        int g = 0;
        while (done_cnt <= base && g < 300) begin
            cyc_wait();
            g++;
        end
        check({tag, "_done_seen"}, (done_cnt > base) ? 1 : 0, 1);
    endtask

    task automatic wait_launches(input int n);
        int g = 0;
        while (q_cyc.size() < n && g < 300) begin
            cyc_wait();
            g++;
        end
        check("launch_reached", (q_cyc.size() >= n) ? 1 : 0, 1);
    endtask

    // Full 4-layer run; exp_off is the done cycle relative to the cycle start is raised.
    task automatic full_run(input string tag, input int exp_off);
        int a, bl, bd;
        bl = q_cyc.size();
        bd = done_cnt;
        a  = cyc;
        start4 = 1'b1;
        cyc_wait();
        start4 = 1'b0;
        wait_done(tag, bd);
        check({tag, "_launches"}, q_cyc.size() - bl, 4);
        for (int i = 0; i < 4; i++) begin
            if (bl + i < q_cyc.size()) begin
                check($sformatf("%s_idx%0d", tag, i), q_idx[bl + i], i);
                check($sformatf("%s_buf%0d", tag, i), q_buf[bl + i], i % 2);
            end
        end
        check({tag, "_done_cyc"}, done_cyc - a, exp_off);
        check({tag, "_error"}, done_err, 0);
        check({tag, "_busy_at_done"}, int'(bus4.busy), 1);
        cyc_wait();
        check({tag, "_busy_after"}, int'(bus4.busy), 0);
        check({tag, "_idx_after"}, int'(bus4.layer_idx), 0);
    endtask

    initial begin
        int a, bl, bd;
        repeat (3) cyc_wait();
        rst = 1'b0;
        cyc_wait();
        check("rst_busy", int'(bus4.busy), 0);
        check("rst_idx", int'(bus4.layer_idx), 0);
        check("rst_buf", int'(bus4.buf_sel), 0);
        check("rst_lstart", int'(bus4.layer_start), 0);
        check("rst_done", int'(bus4.done), 0);
        check("rst_error", int'(bus4.error), 0);
        check("rst_busy1", int'(bus1.busy), 0);

        // Normal run: launches every 7 cycles, done 29 cycles after start is raised
        resp_en = 1'b1;
        full_run("normal", 29);

        // Spurious start/layer_done must not change the sequence
        spur_en = 1'b1;
        full_run("spur", 29);
        spur_en = 1'b0;

        // Instant engine: minimum run length 3*4+2 cycles inclusive
        resp_en = 1'b0;
        hold4   = 1'b1;
        full_run("instant", 13);
        hold4   = 1'b0;

        // Asynchronous reset during WAIT of layer 2
        resp_en = 1'b1;
        bl = q_cyc.size();
        bd = done_cnt;
        start4 = 1'b1;
        cyc_wait();
        start4 = 1'b0;
        wait_launches(bl + 3);
        resp_en = 1'b0;
        repeat (2) cyc_wait();
        check("mid_idx", int'(bus4.layer_idx), 2);
        check("mid_buf", int'(bus4.buf_sel), 0);
        check("mid_busy", int'(bus4.busy), 1);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(bus4.busy), 0);
        check("arst_idx", int'(bus4.layer_idx), 0);
        check("arst_buf", int'(bus4.buf_sel), 0);
        check("arst_done", int'(bus4.done), 0);
        check("arst_error", int'(bus4.error), 0);
        cyc_wait();
        rst = 1'b0;
        repeat (8) cyc_wait();
        check("arst_no_done", done_cnt - bd, 0);
        resp_en = 1'b1;
        full_run("post_rst", 29);

`ifdef CNN_SCHED_TIMEOUT_EN
        // Engine stalls on layer 1: watchdog ends the run 17 cycles after that launch
        bl = q_cyc.size();
        bd = done_cnt;
        start4 = 1'b1;
        cyc_wait();
        start4 = 1'b0;
        wait_launches(bl + 2);
        resp_en = 1'b0;
        wait_done("timeout", bd);
        check("to_launches", q_cyc.size() - bl, 2);
        if (q_cyc.size() >= bl + 2) check("to_cyc", done_cyc - q_cyc[bl + 1], 17);
        check("to_error", done_err, 1);
        repeat (5) cyc_wait();
        check("to_no_more", q_cyc.size() - bl, 2);
        check("to_busy", int'(bus4.busy), 0);
        resp_en = 1'b1;
        full_run("after_to", 29);
`endif

        // Single layer, instant engine: done 4 cycles after start is raised
        hold1 = 1'b1;
        a = cyc;
        start1 = 1'b1;
        cyc_wait();
        start1 = 1'b0;
        for (int g = 0; g < 50 && done1_cnt == 0; g++) cyc_wait();
        check("one_done_seen", done1_cnt, 1);
        check("one_launches", l1_cnt, 1);
        check("one_idx", l1_idx, 0);
        check("one_done_cyc", done1_cyc - a, 4);
        check("one_error", done1_err, 0);
        check("one_buf_never", buf1_seen, 0);
        cyc_wait();
        check("one_busy_after", int'(bus1.busy), 0);
        hold1 = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cnn_layer_scheduler.md
# cnn_layer_scheduler

Top-level sequencer for the CNN accelerator. It runs a fixed number of layer passes back-to-back on a shared compute engine such as `convolution`, using a start/done handshake for each layer. Between passes it toggles a ping-pong buffer select, so that each layer reads the previous layer's output bank. It sits between the host-facing start/done pair and the engine's `start`/`done` pins.

## Interface
Parameters:
- `NUM_LAYERS`, 4: layer passes per run; must be ≥ 1.
- `TIMEOUT_CYCLES`, 4096: per-layer watchdog limit. Used only when `CNN_SCHED_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: run request. Sampled only in IDLE.
- `layer_done`  in  1: engine completion pulse.
- `layer_start`  out  1: one-cycle engine launch pulse.
- `layer_idx`  out  `$clog2(NUM_LAYERS)` (minimum 1): index of the current layer.
- `buf_sel`  out  1: source bank for the current layer. The engine writes to `~buf_sel`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle run-complete pulse.
- `error`  out  1: qualifies `done`; high means the run was aborted by the watchdog.

## Operation
- Moore FSM with states IDLE, LAUNCH, WAIT, ADVANCE, FINISH. All outputs are registered or decoded directly from the state register.
- **IDLE:**
  - `layer_idx`=0, `buf_sel`=0.
  - `start`=1 → LAUNCH.
- **LAUNCH:** `layer_start`=1 for exactly one cycle, then → WAIT.
- **WAIT:** hold until `layer_done`=1, then → ADVANCE.
- **ADVANCE:**
  - If `layer_idx`==`NUM_LAYERS`-1 → FINISH.
  - Otherwise increment `layer_idx`, toggle `buf_sel`, → LAUNCH.
- **FINISH:**
  - `done`=1 for one cycle, with `error` valid alongside it.
  - Then → IDLE. `layer_idx` and `buf_sel` return to 0 on entering IDLE.
- **Ignored inputs:**
  - `start` outside IDLE is ignored; requests are not queued.
  - `layer_done` outside WAIT is ignored, including a `layer_done` in the same cycle as LAUNCH.
- **`NUM_LAYERS`=1:** the first ADVANCE goes straight to FINISH, and `buf_sel` never toggles.
- **Reset values:**
  - `rst` asserted in any state forces IDLE immediately (asynchronous).
  - All outputs reset to 0, including the timeout counter.
  - A run in progress is abandoned, with no `done` pulse.
- **`error`:**
  - Registered; cleared on entering LAUNCH for layer 0.
  - Meaningful only while `done`=1.

## Timing
- `start` high at edge N → `layer_start` high during cycle N+1.
- `layer_done` sampled at edge T:
  - Non-final layer: ADVANCE in cycle T+1, next `layer_start` in cycle T+2.
  - Final layer: ADVANCE in cycle T+1, `done` in cycle T+2.
- `layer_idx` and `buf_sel` are stable from LAUNCH through WAIT. They change only on the ADVANCE→LAUNCH edge.
- Minimum run length with an instant engine (`layer_done` in the first WAIT cycle): 3·`NUM_LAYERS`+2 cycles from `start` to `done`, inclusive.
- `busy` rises in the cycle after `start` is sampled and falls in the cycle after `done`.

## Configuration
- Macro: `CNN_SCHED_TIMEOUT_EN`.
- **Defined:**
  - A counter runs in WAIT and clears on entering LAUNCH.
  - If it reaches `TIMEOUT_CYCLES` with no `layer_done` → FINISH with `error`=1; the remaining layers are skipped.
  - If `layer_done` arrives in the same cycle as the timeout, `layer_done` wins.
- **Undefined:**
  - No counter is instantiated, and `error` is tied to 0.
  - WAIT waits indefinitely.

## Structure
- Shared package `cnn_pkg`:
  - `sched_state_t` enum (IDLE, LAUNCH, WAIT, ADVANCE, FINISH).
  - Localparam helper for the layer-index width.
- Sub-module `cycle_timer`:
  - Loadable down-counter with `clear`, `en`, `expired`.
  - Instantiated only under `CNN_SCHED_TIMEOUT_EN`.
- The FSM and index/bank registers live in the top module.

## Test plan
- **Reset:** `rst` pulse mid-cycle, asynchronous → all outputs 0 before the next edge; FSM in IDLE.
- **Normal run:** `NUM_LAYERS`=4, engine returns `layer_done` 5 cycles after each `layer_start` → four `layer_start` pulses, `layer_idx` 0,1,2,3, `buf_sel` 0,1,0,1, then `done`=1 with `error`=0, `busy` falling the following cycle.
- **Spurious inputs:** `start` re-asserted during WAIT, plus `layer_done` asserted during LAUNCH and ADVANCE → no extra launches, no skipped layers, same sequence as the normal run.
- **Reset mid-run:** `rst` during WAIT of layer 2 → immediate IDLE, no `done`. A new `start` afterwards begins at layer 0 with `buf_sel`=0.
- **Timeout:** with `CNN_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, engine never responds on layer 1 → `done`=1 with `error`=1 about 16 cycles after layer 1's `layer_start`; layers 2 and 3 are never launched.
- **Single layer:** `NUM_LAYERS`=1, instant `layer_done` → `start`@N, `layer_start`@N+1, `done`@N+4; `buf_sel` stays 0 throughout.
